// File: rtl/hssl_rx_pkt_merger.sv
// Round-robin merger of the eight HSSL received-packet streams into one registered, channel-tagged stream.
// Optional per-channel accept counters are built when HSSL_RX_MERGE_CNT_EN is defined.
module hssl_rx_pkt_merger #(
    parameter int PKT_W  = 72,
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             handshake_complete_in,
    input  logic [PKT_W-1:0] rx_pkt0_data_in,
    input  logic             rx_pkt0_vld_in,
    output logic             rx_pkt0_rdy_out,
    input  logic [PKT_W-1:0] rx_pkt1_data_in,
    input  logic             rx_pkt1_vld_in,
    output logic             rx_pkt1_rdy_out,
    input  logic [PKT_W-1:0] rx_pkt2_data_in,
    input  logic             rx_pkt2_vld_in,
    output logic             rx_pkt2_rdy_out,
    input  logic [PKT_W-1:0] rx_pkt3_data_in,
    input  logic             rx_pkt3_vld_in,
    output logic             rx_pkt3_rdy_out,
    input  logic [PKT_W-1:0] rx_pkt4_data_in,
    input  logic             rx_pkt4_vld_in,
    output logic             rx_pkt4_rdy_out,
    input  logic [PKT_W-1:0] rx_pkt5_data_in,
    input  logic             rx_pkt5_vld_in,
    output logic             rx_pkt5_rdy_out,
    input  logic [PKT_W-1:0] rx_pkt6_data_in,
    input  logic             rx_pkt6_vld_in,
    output logic             rx_pkt6_rdy_out,
    input  logic [PKT_W-1:0] rx_pkt7_data_in,
    input  logic             rx_pkt7_vld_in,
    output logic             rx_pkt7_rdy_out,
    output logic [PKT_W-1:0] pkt_data_out,
    output logic [2:0]       pkt_ch_out,
    output logic             pkt_vld_out,
    input  logic             pkt_rdy_in,
    input  logic [2:0]       cnt_sel_in,
    input  logic             cnt_clr_in,
    output logic [CNT_W-1:0] cnt_out
);

    logic [PKT_W-1:0]  ch_data [NUM_CH];
    logic [NUM_CH-1:0] ch_vld;
    logic [NUM_CH-1:0] rdy_vec;

    logic [PKT_W-1:0]  pkt_data_p0;
    logic [2:0]        pkt_ch_p0;
    logic              vld_p0;
    logic [2:0]        ptr;

    logic [2:0]        grant;
    logic [2:0]        idx;
    logic              found;
    logic              slot_free;
    logic              take;

    assign ch_data[0] = rx_pkt0_data_in;
    assign ch_data[1] = rx_pkt1_data_in;
    assign ch_data[2] = rx_pkt2_data_in;
    assign ch_data[3] = rx_pkt3_data_in;
    assign ch_data[4] = rx_pkt4_data_in;
    assign ch_data[5] = rx_pkt5_data_in;
    assign ch_data[6] = rx_pkt6_data_in;
    assign ch_data[7] = rx_pkt7_data_in;

    assign ch_vld = {rx_pkt7_vld_in, rx_pkt6_vld_in, rx_pkt5_vld_in, rx_pkt4_vld_in,
                     rx_pkt3_vld_in, rx_pkt2_vld_in, rx_pkt1_vld_in, rx_pkt0_vld_in};

    // Search starts at ptr so the channel after the last winner has top priority.
    always_comb begin
        grant = 3'd0;
        idx   = 3'd0;
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = ptr + 3'(i);
            if (!found && ch_vld[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    assign slot_free = ~vld_p0 | pkt_rdy_in;
    assign take      = slot_free & handshake_complete_in & ~reset & found;
    assign rdy_vec   = take ? (NUM_CH'(1) << grant) : '0;

    assign {rx_pkt7_rdy_out, rx_pkt6_rdy_out, rx_pkt5_rdy_out, rx_pkt4_rdy_out,
            rx_pkt3_rdy_out, rx_pkt2_rdy_out, rx_pkt1_rdy_out, rx_pkt0_rdy_out} = rdy_vec;

    // Stage p0: single output register, refilled in the same cycle it drains.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_data_p0 <= '0;
            pkt_ch_p0   <= 3'd0;
            vld_p0      <= 1'b0;
            ptr         <= 3'd0;
        end else if (take) begin
            pkt_data_p0 <= ch_data[grant];
            pkt_ch_p0   <= grant;
            vld_p0      <= 1'b1;
            ptr         <= grant + 3'd1;
        end else if (vld_p0 && pkt_rdy_in) begin
            vld_p0      <= 1'b0;
        end
    end

    assign pkt_data_out = pkt_data_p0;
    assign pkt_ch_out   = pkt_ch_p0;
    assign pkt_vld_out  = vld_p0;

`ifdef HSSL_RX_MERGE_CNT_EN
    logic [CNT_W-1:0] cnt [NUM_CH];
    logic [CNT_W-1:0] cnt_p0;

    // Clear has priority over a same-cycle accept increment.
    always_ff @(posedge clk) begin
        if (reset || cnt_clr_in) begin
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
        end else if (take) begin
            cnt[grant] <= cnt[grant] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_p0 <= '0;
        else       cnt_p0 <= cnt[cnt_sel_in];
    end

    assign cnt_out = cnt_p0;
`else
    logic unused_cnt_ctrl;
    assign unused_cnt_ctrl = ^{cnt_sel_in, cnt_clr_in};
    assign cnt_out = '0;
`endif

endmodule

// File: tb/tb_hssl_rx_pkt_merger.sv
// Directed and randomized bench for hssl_rx_pkt_merger against a cycle-level behavioural model.
// Counter checks follow HSSL_RX_MERGE_CNT_EN the same way the design does.
module tb_hssl_rx_pkt_merger;

    logic        clk = 1'b0;
    logic        reset;
    logic        hs;
    logic [71:0] d [8];
    logic [7:0]  v;
    logic        rdy_in;
    logic [2:0]  cnt_sel;
    logic        cnt_clr;
    logic [7:0]  rdy_out;
    logic [71:0] pkt_data;
    logic [2:0]  pkt_ch;
    logic        pkt_vld;
    logic [31:0] cnt_out;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    bit          m_vld;
    logic [71:0] m_data;
    int          m_ch;
    int          m_ptr;
    int unsigned m_cnt [8];
    int unsigned m_cnt_out;

    always #5 clk = ~clk;

    hssl_rx_pkt_merger dut (
        .clk(clk), .reset(reset), .handshake_complete_in(hs),
        .rx_pkt0_data_in(d[0]), .rx_pkt0_vld_in(v[0]), .rx_pkt0_rdy_out(rdy_out[0]),
        .rx_pkt1_data_in(d[1]), .rx_pkt1_vld_in(v[1]), .rx_pkt1_rdy_out(rdy_out[1]),
        .rx_pkt2_data_in(d[2]), .rx_pkt2_vld_in(v[2]), .rx_pkt2_rdy_out(rdy_out[2]),
        .rx_pkt3_data_in(d[3]), .rx_pkt3_vld_in(v[3]), .rx_pkt3_rdy_out(rdy_out[3]),
        .rx_pkt4_data_in(d[4]), .rx_pkt4_vld_in(v[4]), .rx_pkt4_rdy_out(rdy_out[4]),
        .rx_pkt5_data_in(d[5]), .rx_pkt5_vld_in(v[5]), .rx_pkt5_rdy_out(rdy_out[5]),
        .rx_pkt6_data_in(d[6]), .rx_pkt6_vld_in(v[6]), .rx_pkt6_rdy_out(rdy_out[6]),
        .rx_pkt7_data_in(d[7]), .rx_pkt7_vld_in(v[7]), .rx_pkt7_rdy_out(rdy_out[7]),
        .pkt_data_out(pkt_data), .pkt_ch_out(pkt_ch), .pkt_vld_out(pkt_vld),
        .pkt_rdy_in(rdy_in), .cnt_sel_in(cnt_sel), .cnt_clr_in(cnt_clr), .cnt_out(cnt_out)
    );

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: check combinational ready, advance model, check registered outputs.
    task automatic step();
        bit take;
        int g;
        #1;
        take = 1'b0;
        g = -1;
        for (int k = 0; k < 8; k++)
            if (g < 0 && v[(m_ptr + k) % 8]) g = (m_ptr + k) % 8;
        take = (!m_vld || rdy_in) && hs && !reset && (g >= 0);
        chk("rdy_out", {64'd0, rdy_out}, take ? (72'd1 << g) : 72'd0);
        @(posedge clk);
        #1;
        if (reset) begin
            m_vld = 0; m_data = '0; m_ch = 0; m_ptr = 0; m_cnt_out = 0;
            for (int k = 0; k < 8; k++) m_cnt[k] = 0;
        end else begin
`ifdef HSSL_RX_MERGE_CNT_EN
            m_cnt_out = m_cnt[cnt_sel];
            if (cnt_clr) for (int k = 0; k < 8; k++) m_cnt[k] = 0;
            else if (take) m_cnt[g] = m_cnt[g] + 1;
`else
            m_cnt_out = 0;
`endif
            if (take) begin
                m_vld = 1; m_data = d[g]; m_ch = g; m_ptr = (g + 1) % 8;
            end else if (m_vld && rdy_in) begin
                m_vld = 0;
            end
        end
        chk("pkt_vld", {71'd0, pkt_vld}, {71'd0, m_vld});
        chk("pkt_data", pkt_data, m_data);
        chk("pkt_ch", {69'd0, pkt_ch}, 72'(m_ch));
        chk("cnt_out", {40'd0, cnt_out}, {40'd0, m_cnt_out});
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int k = 0; k < n; k++) step();
        reset = 1'b0;
    endtask

    task automatic set_vld(input logic [7:0] mask);
        v = mask;
        for (int k = 0; k < 8; k++) d[k] = {8'(k), 32'($urandom), 32'($urandom)};
    endtask

    initial begin
        reset = 1'b1; hs = 1'b0; v = '0; rdy_in = 1'b0; cnt_sel = '0; cnt_clr = 1'b0;
        for (int k = 0; k < 8; k++) d[k] = '0;
        m_vld = 0; m_data = '0; m_ch = 0; m_ptr = 0; m_cnt_out = 0;
        for (int k = 0; k < 8; k++) m_cnt[k] = 0;

        // reset, then a single ch3 packet
        do_reset(4);
        chk("rst_vld", {71'd0, pkt_vld}, 72'd0);
        chk("rst_data", pkt_data, 72'd0);
        hs = 1'b1; rdy_in = 1'b1; v = 8'h08; d[3] = 72'h3_0000_0001;
        step();
        chk("t1_data", pkt_data, 72'h3_0000_0001);
        chk("t1_ch", {69'd0, pkt_ch}, 72'd3);
        v = '0;
        step();

        // all channels valid: round-robin 0..7 twice
        do_reset(1);
        for (int k = 0; k < 16; k++) begin
            set_vld(8'hFF);
            step();
            chk("t2_order", {69'd0, pkt_ch}, 72'(k % 8));
        end
        v = '0; step();

        // ch5 held against back-pressure, then drain with same-cycle refill
        rdy_in = 1'b0;
        set_vld(8'h20);
        for (int k = 0; k < 10; k++) step();
        rdy_in = 1'b1;
        for (int k = 0; k < 3; k++) begin set_vld(8'h20); step(); end
        v = '0; step();

        // handshake low blocks intake; ch0 first once enabled after reset
        do_reset(1);
        hs = 1'b0;
        set_vld(8'hFF);
        for (int k = 0; k < 3; k++) step();
        hs = 1'b1;
        step();
        chk("t4_first", {69'd0, pkt_ch}, 72'd0);

        // pointer wrap: last grant ch6, then ch2 and ch7 compete
        set_vld(8'h40); step();
        set_vld(8'h84); step();
        chk("t5_ch7", {69'd0, pkt_ch}, 72'd7);
        set_vld(8'h84); step();
        chk("t5_ch2", {69'd0, pkt_ch}, 72'd2);
        v = '0; step();

        // reset asserted while a packet is held
        rdy_in = 1'b0; set_vld(8'h02); step(); step();
        do_reset(1);
        rdy_in = 1'b1; v = '0; step();

`ifdef HSSL_RX_MERGE_CNT_EN
        do_reset(1);
        for (int k = 0; k < 5; k++) begin set_vld(8'h02); step(); end
        for (int k = 0; k < 3; k++) begin set_vld(8'h40); step(); end
        v = '0; cnt_sel = 3'd1; step(); step();
        chk("t6_cnt1", {40'd0, cnt_out}, 72'd5);
        cnt_sel = 3'd6; step(); step();
        chk("t6_cnt6", {40'd0, cnt_out}, 72'd3);
        cnt_sel = 3'd1; cnt_clr = 1'b1; set_vld(8'h02); step();
        cnt_clr = 1'b0; v = '0; step(); step();
        chk("t6_clr", {40'd0, cnt_out}, 72'd0);
`else
        cnt_sel = 3'd5; cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
        chk("t6_cnt_tied", {40'd0, cnt_out}, 72'd0);
`endif

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            set_vld(8'($urandom));
            rdy_in  = ($urandom_range(0, 9) < 7);
            hs      = ($urandom_range(0, 9) != 0);
            reset   = ($urandom_range(0, 99) == 0);
            cnt_sel = 3'($urandom);
            cnt_clr = ($urandom_range(0, 49) == 0);
            step();
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
